// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nsa_pkg;

   localparam int              NIB_W      = 4;
   localparam logic [NIB_W-1:0] FIX_ADDEND = 4'd1;

   typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// Drives an external carry-less 4-bit adder one nibble per step to build a
// NIBBLES*4-bit sum; an incoming carry costs an extra "+1" pass per nibble.
module nibble_serial_add_ctrl
   import nsa_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIB_W*NIBBLES-1:0] op_a,
   input  logic [NIB_W*NIBBLES-1:0] op_b,
   output logic [NIB_W-1:0]         add_a,
   output logic [NIB_W-1:0]         add_b,
   input  logic [NIB_W-1:0]         add_s,
   input  logic                     add_c,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIB_W*NIBBLES-1:0] result,
   output logic                     carry_out
);

   localparam int W     = NIB_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
   logic [NIB_W-1:0]   tmp_q, tmp_d;
   logic               carry_q, carry_d, c1_q, c1_d, cout_q, cout_d;
   logic               adv;
   int                 sel;

   assign sel       = int'(idx_q) * NIB_W;
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign carry_out = cout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         tmp_q   <= '0;
         carry_q <= 1'b0;
         c1_q    <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         tmp_q   <= tmp_d;
         carry_q <= carry_d;
         c1_q    <= c1_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      tmp_d   = tmp_q;
      carry_d = carry_q;
      c1_d    = c1_q;
      cout_d  = cout_q;
      add_a   = '0;
      add_b   = '0;
      adv     = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               idx_d   = '0;
               carry_d = 1'b0;
               res_d   = '0;
               cout_d  = 1'b0;
               state_d = ADD;
            end
         end
         ADD: begin
            add_a = a_q[sel +: NIB_W];
            add_b = b_q[sel +: NIB_W];
            tmp_d = add_s;
            c1_d  = add_c;
            if (carry_q) begin
               state_d = FIX;
            end else begin
               res_d[sel +: NIB_W] = add_s;
               carry_d             = add_c;
               adv                 = 1'b1;
            end
         end
         FIX: begin
            // tmp+1 only carries when tmp==F, which the first pass can't produce with c1 set
            add_a               = tmp_q;
            add_b               = FIX_ADDEND;
            res_d[sel +: NIB_W] = add_s;
            carry_d             = c1_q | add_c;
            adv                 = 1'b1;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (adv) begin
         if (idx_q == IDX_LAST) begin
            state_d = DONE;
            cout_d  = carry_d;
         end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ADD;
         end
      end
   end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs a wide (NIBBLES×4-bit) addition by driving the team's combinational 4-bit adder F_adder one nibble per step.
- F_adder ports: a, b, s, c_out; it has no carry-in.
- Sits directly upstream of F_adder (feeds a/b) and downstream of it (consumes s/c_out).
- Carry between nibbles is applied by a second "fix-up" pass through the same adder (add 1).

Parameters:
- NIBBLES, 4, number of 4-bit digits per operand (operand width = 4*NIBBLES); legal range 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- op_a  in  4*NIBBLES  operand A
- op_b  in  4*NIBBLES  operand B
- add_a  out  4  to F_adder .a
- add_b  out  4  to F_adder .b
- add_s  in  4  from F_adder .s
- add_c  in  1  from F_adder .c_out
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  4*NIBBLES  sum modulo 2^(4*NIBBLES)
- carry_out  out  1  carry out of the most significant nibble

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; idx, carry, tmp, c1 cleared.
  - result=0, carry_out=0, out_valid=0.
  - add_a=add_b=0.
  - in_valid is ignored while rst_n=0.
- in_ready is combinational: 1 only when state==IDLE.
- add_a/add_b are combinational from state.
- add_s/add_c are sampled at the rising edge ending the cycle in which add_a/add_b are driven; F_adder is combinational.
- States:
  - IDLE: add_a=add_b=0.
    - On in_valid&&in_ready: latch op_a/op_b, idx=0, carry=0, clear result/carry_out; -> ADD.
  - ADD: add_a=A[idx], add_b=B[idx].
    - At edge: tmp=add_s, c1=add_c.
    - If carry==1 -> FIX.
    - Else: result[idx]=add_s, carry=add_c, then advance.
  - FIX: add_a=tmp, add_b=4'd1.
    - At edge: result[idx]=add_s, carry=c1|add_c (c1 and add_c are never both 1).
    - Then advance.
  - Advance: if idx==NIBBLES-1 -> DONE with carry_out=final carry; else idx++ -> ADD.
  - DONE: out_valid=1; result/carry_out held stable.
    - On out_ready -> IDLE; out_valid drops the next cycle.
- No acceptance in DONE; back-to-back operations cost one IDLE cycle.
- Latency:
  - out_valid rises NIBBLES+F cycles after the accepting edge, where F = number of nibbles entered with carry-in 1.
  - Range NIBBLES .. 2*NIBBLES-1.
- Operand changes on op_a/op_b after acceptance have no effect.
- Reset mid-operation: immediate return to IDLE; partial result discarded; out_valid=0.
- Backpressure: out_ready low holds DONE indefinitely; outputs are stable throughout.
- out_ready high outside DONE is ignored.
- Overflow: result wraps modulo 2^(4*NIBBLES); carry_out is the only overflow indicator.

Decomposition:
- Shared package nsa_pkg:
  - state typedef {IDLE, ADD, FIX, DONE}
  - NIB_W=4
  - FIX_ADDEND=4'd1
- Nibble select and result insert are indexed part-selects in-module.
- No sub-module required. F_adder is instantiated beside this block in the enclosing top level; the bench does the same.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> in_ready=1, out_valid=0, result=0, carry_out=0, add_a=add_b=0.
- No-carry add (NIBBLES=4): 0x1234+0x4321 -> result=0x5555, carry_out=0, out_valid exactly 4 cycles after accept, no FIX state visited.
- Ripple carry: 0xFFFF+0x0001 -> result=0x0000, carry_out=1, latency 7 (3 FIX cycles); add_a/add_b sequence F/1, F/0, 0xF/1, F/0, F/1, F/0, F/1.
- Max operands: 0xFFFF+0xFFFF -> result=0xFFFE, carry_out=1, latency 7.
- Backpressure and handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid/result stable; in_valid during DONE not accepted.
  - Then out_ready=1 -> IDLE, next op 0x0F0F+0x0101 accepted -> 0x1010, carry_out=0.
- Reset mid-operation: assert rst_n=0 during the FIX of nibble 1 of 0xFFFF+0x0001 -> immediate IDLE, out_valid=0, result=0; the next op 0x0002+0x0003 yields 0x0005 in 4 cycles.
